if_fetch_stage: RTL and testbench

- Instruction-fetch stage. Owns the PC, drives the synchronous instruction memory, and delivers {inst, pc} to the IF/ID boundary under a valid/ready handshake.
- Supports decode back-pressure through a 2-entry skid FIFO that absorbs the 1-cycle memory read latency.
- Supports branch/jump redirect from downstream, which flushes wrong-path fetches.
- Sits between the instruction memory and the IF/ID register feeding the decode/datapath.

---
 rtl/if_fetch_stage_pkg.sv | 20 ++
 rtl/if_fetch_stage_if.sv | 29 ++
 rtl/if_fetch_stage_skid_fifo.sv | 55 +++++
 rtl/if_fetch_stage.sv | 82 ++++++++
 tb/tb_if_fetch_stage.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared widths, reset constants and the fetch credit rule for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam int unsigned IF_AW       = 32;
  localparam int unsigned IF_IW       = 32;
  localparam logic [IF_AW-1:0] IF_RESET_PC = '0;
  localparam int unsigned IF_PC_STEP  = 1;
  localparam int unsigned FIFO_DEPTH  = 2;
  localparam int unsigned CNT_W       = 2;
  localparam int unsigned USED_W      = CNT_W + 1;
  localparam int unsigned FETCH_CNT_W = 32;

  // A new request is legal only when its response is guaranteed a FIFO slot next cycle.
  function automatic logic credit_ok(logic [CNT_W-1:0] count, logic inflight, logic pop);
    logic [USED_W-1:0] used;
    used = USED_W'(count) + USED_W'(inflight) - USED_W'(pop);
    return used < USED_W'(FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/response, decode valid/ready and redirect control.
interface if_fetch_stage_if #(
  parameter int unsigned AW = if_fetch_stage_pkg::IF_AW,
  parameter int unsigned IW = if_fetch_stage_pkg::IF_IW
);

  logic                                       fetch_en;
  logic                                       redirect_valid;
  logic [AW-1:0]                              redirect_pc;
  logic                                       imem_req;
  logic [AW-1:0]                              imem_addr;
  logic [IW-1:0]                              imem_rdata;
  logic                                       inst_valid;
  logic                                       inst_ready;
  logic [IW-1:0]                              inst;
  logic [AW-1:0]                              inst_pc;
  logic [if_fetch_stage_pkg::FETCH_CNT_W-1:0] fetch_cnt;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_cnt
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_cnt
  );

endinterface

// File: rtl/if_fetch_stage_skid_fifo.sv
// Two-entry skid FIFO holding {inst, pc} between the 1-cycle memory and decode.
module if_fetch_stage_skid_fifo
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned W = IF_IW + IF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [W-1:0]     head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [FIFO_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Flush wins over push/pop so a redirect leaves the FIFO empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited memory reads and handles redirects.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned   AW       = IF_AW,
  parameter int unsigned   IW       = IF_IW,
  parameter logic [AW-1:0] RESET_PC = AW'(IF_RESET_PC),
  parameter int unsigned   PC_STEP  = IF_PC_STEP
) (
  input  logic             clk,
  input  logic             rst,
  if_fetch_stage_if.master bus
);

  localparam int unsigned EW = IW + AW;

  logic [AW-1:0]          pc_q, pc_d;
  logic [AW-1:0]          req_pc_q, req_pc_d;
  logic                   inflight_q, inflight_d;
  logic [FETCH_CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0]       fifo_count;
  logic [EW-1:0]          fifo_head;
  logic [AW-1:0]          fetch_addr;
  logic                   flush, pop, push, issue, inst_valid;

  assign inst_valid = (fifo_count != '0);

  // A redirect flushes the FIFO, drops the response landing this cycle and refetches at once.
  always_comb begin
    flush       = bus.redirect_valid;
    pop         = inst_valid && bus.inst_ready && !flush;
    push        = inflight_q && !flush;
    fetch_addr  = flush ? bus.redirect_pc : pc_q;
    issue       = bus.fetch_en && (flush || credit_ok(fifo_count, inflight_q, pop));
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    inflight_d  = issue;
    fetch_cnt_d = fetch_cnt_q + FETCH_CNT_W'(pop);
    if (issue) begin
      pc_d     = fetch_addr + AW'(PC_STEP);
      req_pc_d = fetch_addr;
    end else if (flush) begin
      pc_d     = bus.redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      inflight_q  <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      inflight_q  <= inflight_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  if_fetch_stage_skid_fifo #(
    .W (EW)
  ) u_fetch_skid_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ({bus.imem_rdata, req_pc_q}),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  // The request strobe is combinational, so it is masked while reset is held.
  assign bus.imem_req   = issue && rst;
  assign bus.imem_addr  = fetch_addr;
  assign bus.inst_valid = inst_valid;
  assign bus.inst       = fifo_head[EW-1:AW];
  assign bus.inst_pc    = fifo_head[AW-1:0];
  assign bus.fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized traffic against a queue-based model.
module tb_if_fetch_stage;

  logic clk = 1'b0;
  logic rst;

  if_fetch_stage_if bus ();

  if_fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  // Reference model: queue of deliverable entries, one pending read, next fetch PC, handshake count.
  entry_t      m_q[$];
  logic        m_inflight;
  logic [31:0] m_infl_addr;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] mem_key;
  logic        e_req, e_valid, e_pop;
  logic [31:0] e_addr;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ mem_key;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_inflight  = 1'b0;
    m_infl_addr = '0;
    m_pc        = '0;
    m_cnt       = '0;
  endtask

  task automatic model_eval();
    e_valid = (m_q.size() != 0);
    e_pop   = e_valid && bus.inst_ready && !bus.redirect_valid;
    e_addr  = bus.redirect_valid ? bus.redirect_pc : m_pc;
    if (!bus.fetch_en)          e_req = 1'b0;
    else if (bus.redirect_valid) e_req = 1'b1;
    else e_req = (m_q.size() + int'(m_inflight) - int'(e_pop)) < 2;
  endtask

  task automatic model_commit();
    entry_t e;
    if (bus.redirect_valid) begin
      m_q.delete();
    end else begin
      if (e_pop) void'(m_q.pop_front());
      if (m_inflight) begin
        e.inst = mem_word(m_infl_addr);
        e.pc   = m_infl_addr;
        m_q.push_back(e);
      end
    end
    if (e_pop) m_cnt = m_cnt + 32'd1;
    if (e_req) m_pc = e_addr + 32'd1;
    else if (bus.redirect_valid) m_pc = bus.redirect_pc;
    m_inflight  = e_req;
    m_infl_addr = e_addr;
  endtask

  // Advance one clock from mid-cycle; memory answers the request seen before the edge.
  task automatic tick();
    logic        req;
    logic [31:0] a;
    model_eval();
    req = bus.imem_req;
    a   = bus.imem_addr;
    model_commit();
    @(posedge clk);
    #1;
    bus.imem_rdata = req ? mem_word(a) : $urandom();
  endtask

  task automatic do_reset();
    rst                = 1'b0;
    bus.fetch_en       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    bus.imem_rdata     = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    rst            = 1'b0;
    bus.fetch_en   = 1'b1;
    bus.inst_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b req=%b expected 0/0", bus.inst_valid, bus.imem_req);
    end
    checks++;
    if (bus.inst !== 32'd0 || bus.inst_pc !== 32'd0 || bus.fetch_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: inst=%h pc=%h cnt=%0d expected all 0", bus.inst, bus.inst_pc, bus.fetch_cnt);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h expected 1/00000000", bus.imem_req, bus.imem_addr);
    end
    tick();
  endtask

  task automatic test_stream();
    do_reset();
    mem_key        = '0;
    bus.fetch_en   = 1'b1;
    bus.inst_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(c)) begin
        errors++;
        $display("FAIL stream_req c%0d: req=%b addr=%h expected 1/%h", c, bus.imem_req, bus.imem_addr, 32'(c));
      end
      checks++;
      if (bus.inst_valid !== (c >= 2)) begin
        errors++;
        $display("FAIL stream_valid c%0d: got %b expected %b", c, bus.inst_valid, (c >= 2));
      end
      if (c >= 2) begin
        checks++;
        if (bus.inst_pc !== 32'(c - 2) || bus.inst !== 32'(c - 2)) begin
          errors++;
          $display("FAIL stream_data c%0d: inst=%h pc=%h expected %h", c, bus.inst, bus.inst_pc, 32'(c - 2));
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (bus.fetch_cnt !== 32'd5) begin
      errors++;
      $display("FAIL stream_cnt: got %0d expected 5", bus.fetch_cnt);
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_key      = '0;
    bus.fetch_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.inst_ready = !(c >= 5 && c <= 8);
      @(negedge clk);
      if (c >= 5 && c <= 8) begin
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'd3 || bus.inst !== 32'd3) begin
          errors++;
          $display("FAIL bp_hold c%0d: valid=%b inst=%h pc=%h expected 1/3/3", c, bus.inst_valid, bus.inst, bus.inst_pc);
        end
        checks++;
        if (bus.imem_req !== 1'b0) begin
          errors++;
          $display("FAIL bp_req c%0d: got %b expected 0", c, bus.imem_req);
        end
      end else if (c >= 9) begin
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(c - 6) || bus.inst !== 32'(c - 6)) begin
          errors++;
          $display("FAIL bp_resume c%0d: valid=%b pc=%h expected 1/%h", c, bus.inst_valid, bus.inst_pc, 32'(c - 6));
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (bus.fetch_cnt !== 32'd6) begin
      errors++;
      $display("FAIL bp_cnt: got %0d expected 6", bus.fetch_cnt);
    end
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    mem_key        = '0;
    bus.fetch_en   = 1'b1;
    bus.inst_ready = 1'b1;
    bus.redirect_pc = 32'h40;
    for (int c = 0; c < 13; c++) begin
      bus.redirect_valid = (c == 9);
      @(negedge clk);
      if (c == 9) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40 || bus.inst_pc !== 32'd7) begin
          errors++;
          $display("FAIL redir_cycle: req=%b addr=%h head=%h expected 1/40/7", bus.imem_req, bus.imem_addr, bus.inst_pc);
        end
      end
      if (c == 10) begin
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.fetch_cnt !== 32'd7 || bus.imem_addr !== 32'h41) begin
          errors++;
          $display("FAIL redir_flush: valid=%b cnt=%0d addr=%h expected 0/7/41", bus.inst_valid, bus.fetch_cnt, bus.imem_addr);
        end
      end
      if (c == 11 || c == 12) begin
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(32'h40 + c - 11) || bus.inst !== 32'(32'h40 + c - 11)) begin
          errors++;
          $display("FAIL redir_target c%0d: valid=%b pc=%h expected 1/%h", c, bus.inst_valid, bus.inst_pc, 32'(32'h40 + c - 11));
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (bus.fetch_cnt !== 32'd9) begin
      errors++;
      $display("FAIL redir_cnt: got %0d expected 9", bus.fetch_cnt);
    end
    tick();
  endtask

  task automatic test_redirect_pop();
    do_reset();
    mem_key         = '0;
    bus.redirect_pc = 32'h80;
    for (int c = 0; c < 11; c++) begin
      bus.inst_ready     = !(c >= 4 && c <= 5);
      bus.fetch_en       = !(c == 6 || c == 7);
      bus.redirect_valid = (c == 6);
      @(negedge clk);
      if (c == 6) begin
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.fetch_cnt !== 32'd2) begin
          errors++;
          $display("FAIL rpop_cycle: valid=%b req=%b cnt=%0d expected 1/0/2", bus.inst_valid, bus.imem_req, bus.fetch_cnt);
        end
      end
      if (c == 7) begin
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.fetch_cnt !== 32'd2 || bus.imem_req !== 1'b0) begin
          errors++;
          $display("FAIL rpop_after: valid=%b cnt=%0d req=%b expected 0/2/0", bus.inst_valid, bus.fetch_cnt, bus.imem_req);
        end
      end
      if (c == 8) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h80) begin
          errors++;
          $display("FAIL rpop_pc: req=%b addr=%h expected 1/80", bus.imem_req, bus.imem_addr);
        end
      end
      if (c == 10) begin
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h80) begin
          errors++;
          $display("FAIL rpop_deliver: valid=%b pc=%h expected 1/80", bus.inst_valid, bus.inst_pc);
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_key      = '0;
    bus.fetch_en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.inst_ready = (c < 4);
      @(negedge clk);
      if (c < 5) tick();
    end
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.fetch_cnt !== 32'd2) begin
      errors++;
      $display("FAIL areset_pre: valid=%b cnt=%0d expected 1/2", bus.inst_valid, bus.fetch_cnt);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.fetch_cnt !== 32'd0) begin
      errors++;
      $display("FAIL areset_now: valid=%b req=%b cnt=%0d expected 0/0/0", bus.inst_valid, bus.imem_req, bus.fetch_cnt);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    bus.inst_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(c)) begin
        errors++;
        $display("FAIL areset_restart c%0d: req=%b addr=%h expected 1/%h", c, bus.imem_req, bus.imem_addr, 32'(c));
      end
      if (c == 2) begin
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'd0) begin
          errors++;
          $display("FAIL areset_first: valid=%b pc=%h expected 1/0", bus.inst_valid, bus.inst_pc);
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mem_key         = '0;
    bus.inst_ready  = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    for (int c = 0; c < 7; c++) begin
      bus.redirect_valid = (c == 0);
      bus.fetch_en       = (c == 0);
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFF) begin
          errors++;
          $display("FAIL wrap_req: req=%b addr=%h expected 1/ffffffff", bus.imem_req, bus.imem_addr);
        end
      end else if (c == 1) begin
        checks++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'd0) begin
          errors++;
          $display("FAIL wrap_next: req=%b addr=%h expected 0/00000000", bus.imem_req, bus.imem_addr);
        end
      end else if (c == 2) begin
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'hFFFF_FFFF || bus.inst !== 32'hFFFF_FFFF) begin
          errors++;
          $display("FAIL wrap_deliver: valid=%b pc=%h expected 1/ffffffff", bus.inst_valid, bus.inst_pc);
        end
      end else begin
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.fetch_cnt !== 32'd1) begin
          errors++;
          $display("FAIL wrap_idle c%0d: valid=%b req=%b cnt=%0d expected 0/0/1", c, bus.inst_valid, bus.imem_req, bus.fetch_cnt);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    mem_key = $urandom() | 32'h8000_0001;
    for (int c = 0; c < 600; c++) begin
      bus.fetch_en       = ($urandom_range(0, 9) < 8);
      bus.inst_ready     = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 2)))
                                                       : 32'($urandom());
      @(negedge clk);
      model_eval();
      checks++;
      if (bus.imem_req !== e_req || bus.imem_addr !== e_addr) begin
        errors++;
        $display("FAIL rand_req c%0d: req=%b addr=%h expected %b/%h", c, bus.imem_req, bus.imem_addr, e_req, e_addr);
      end
      checks++;
      if (bus.inst_valid !== e_valid) begin
        errors++;
        $display("FAIL rand_valid c%0d: got %b expected %b", c, bus.inst_valid, e_valid);
      end
      if (e_valid) begin
        checks++;
        if ({bus.inst, bus.inst_pc} !== m_q[0]) begin
          errors++;
          $display("FAIL rand_head c%0d: got %h/%h expected %h/%h", c, bus.inst, bus.inst_pc, m_q[0].inst, m_q[0].pc);
        end
      end
      checks++;
      if (bus.fetch_cnt !== m_cnt) begin
        errors++;
        $display("FAIL rand_cnt c%0d: got %0d expected %0d", c, bus.fetch_cnt, m_cnt);
      end
      tick();
    end
  endtask

  initial begin
    mem_key = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
